// File: rtl/voice_mix_scheduler_if.sv
// ---------------------------------------------------------------------------
// voice_mix_scheduler_if
//
// Shared voice-sample bus between the mix scheduler (the only master) and
// the voice bank.
//
// Signals:
//   voice_req          master -> slave  request for the sample of voice_idx
//   voice_idx          master -> slave  voice being polled (IDX_W bits)
//   voice_valid        slave  -> master samples for voice_idx are ready
//   voice_sample_left  slave  -> master signed 16-bit left contribution
//   voice_sample_right slave  -> master signed 16-bit right contribution
// ---------------------------------------------------------------------------
interface voice_mix_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             voice_req;
    logic [IDX_W-1:0] voice_idx;
    logic             voice_valid;
    logic [15:0]      voice_sample_left;
    logic [15:0]      voice_sample_right;

    modport master (
        output voice_req,
        output voice_idx,
        input  voice_valid,
        input  voice_sample_left,
        input  voice_sample_right
    );

    modport slave (
        input  voice_req,
        input  voice_idx,
        output voice_valid,
        output voice_sample_left,
        output voice_sample_right
    );
endinterface

// File: rtl/voice_mix_scheduler.sv
// ---------------------------------------------------------------------------
// voice_mix_scheduler
//
// Once per codec frame, polls every voice of the voice bank over the shared
// request/valid bus, accumulates the signed stereo contributions and presents
// the left, right and mono mix together with a one-cycle latch strobe.
//
// Parameters:
//   NUM_VOICES  number of voices polled per frame (1 .. 2**IDX_W)
//   IDX_W       width of voice_idx
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-high reset
//   generate_next_sample one-cycle frame start pulse from the codec conditioner
//   clear_overrun        clears the sticky overrun flag
//   voice_bus            master side of the voice-sample bus
//   new_sample_in_left   mixed left sample (registered)
//   new_sample_in_right  mixed right sample (registered)
//   new_sample_in        mono mix (registered)
//   latch_new_sample_in  one-cycle strobe, all sample outputs valid
//   busy                 high whenever a frame is in progress
//   overrun              sticky: frame pulse arrived while busy
//
// Build option:
//   VOICE_MIX_SATURATE_EN  when defined, each channel is clipped to the
//                          signed 16-bit range; otherwise it wraps.
// ---------------------------------------------------------------------------
module voice_mix_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  generate_next_sample,
    input  logic                  clear_overrun,
    voice_mix_scheduler_if.master voice_bus,
    output logic [15:0]           new_sample_in_left,
    output logic [15:0]           new_sample_in_right,
    output logic [15:0]           new_sample_in,
    output logic                  latch_new_sample_in,
    output logic                  busy,
    output logic                  overrun
);
    // One guard bit beyond the voice count keeps the sum of up to 2**IDX_W
    // full-scale 16-bit samples from ever overflowing.
    localparam int               ACC_W    = 16 + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sum_l;
    logic signed [ACC_W-1:0] sum_r;
    logic [15:0]             clip_l;
    logic [15:0]             clip_r;
    logic [16:0]             mono_sum;
    logic                    mono_unused_lsb;
    logic                    start;
    logic                    accept;
    logic                    last_voice;

    assign start      = generate_next_sample && (state == IDLE);
    assign accept     = (state == REQ) && voice_bus.voice_valid;
    assign last_voice = (idx == LAST_IDX);

    // Running sums including the sample currently on the bus, so the last
    // voice can be folded in and the result registered on the same edge.
    assign sum_l = acc_l + {{(ACC_W-16){voice_bus.voice_sample_left[15]}},
                            voice_bus.voice_sample_left};
    assign sum_r = acc_r + {{(ACC_W-16){voice_bus.voice_sample_right[15]}},
                            voice_bus.voice_sample_right};

`ifdef VOICE_MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 15'h7FFF};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'h0000};

    // Clip each channel to the signed 16-bit range.
    always_comb begin
        clip_l = sum_l[15:0];
        clip_r = sum_r[15:0];
        if (sum_l > SAT_MAX) begin
            clip_l = 16'h7FFF;
        end else if (sum_l < SAT_MIN) begin
            clip_l = 16'h8000;
        end
        if (sum_r > SAT_MAX) begin
            clip_r = 16'h7FFF;
        end else if (sum_r < SAT_MIN) begin
            clip_r = 16'h8000;
        end
    end
`else
    assign clip_l = sum_l[15:0];
    assign clip_r = sum_r[15:0];
`endif

    // Mono is the 17-bit sum halved; taking bits [16:1] is an arithmetic
    // shift right that rounds toward minus infinity.
    assign mono_sum        = {clip_l[15], clip_l} + {clip_r[15], clip_r};
    assign mono_unused_lsb = mono_sum[0];

    assign voice_bus.voice_idx = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a stalled voice holds REQ indefinitely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (generate_next_sample) state_next = REQ;
            REQ:  if (accept && last_voice) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs that decode the registered state directly.
    always_comb begin
        voice_bus.voice_req = (state == REQ);
        busy                = (state != IDLE);
        latch_new_sample_in = (state == DONE);
    end

    // Accumulators, voice index and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx                 <= '0;
            acc_l               <= '0;
            acc_r               <= '0;
            new_sample_in_left  <= 16'h0000;
            new_sample_in_right <= 16'h0000;
            new_sample_in       <= 16'h0000;
        end else if (start) begin
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
        end else if (accept) begin
            acc_l <= sum_l;
            acc_r <= sum_r;
            if (last_voice) begin
                new_sample_in_left  <= clip_l;
                new_sample_in_right <= clip_r;
                new_sample_in       <= mono_sum[16:1];
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Sticky overrun; a new overrun outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (generate_next_sample && busy) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voice_mix_scheduler
//
// Self-checking bench for voice_mix_scheduler (NUM_VOICES=4, IDX_W=2).
// A table of frames drives the voice bank; expected mixes go into a
// scoreboard queue and are compared whenever the latch strobe appears.
// Hand-written sequences cover overrun handling and reset mid-frame.
// Honours VOICE_MIX_SATURATE_EN for the clipping expectations.
// ---------------------------------------------------------------------------
module tb_voice_mix_scheduler;
    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        generate_next_sample;
    logic        clear_overrun;
    logic [15:0] new_sample_in_left;
    logic [15:0] new_sample_in_right;
    logic [15:0] new_sample_in;
    logic        latch_new_sample_in;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    voice_mix_scheduler_if #(.IDX_W(2)) vbus ();

    voice_mix_scheduler #(
        .NUM_VOICES(NV),
        .IDX_W     (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .generate_next_sample(generate_next_sample),
        .clear_overrun       (clear_overrun),
        .voice_bus           (vbus),
        .new_sample_in_left  (new_sample_in_left),
        .new_sample_in_right (new_sample_in_right),
        .new_sample_in       (new_sample_in),
        .latch_new_sample_in (latch_new_sample_in),
        .busy                (busy),
        .overrun             (overrun)
    );

    typedef struct packed {
        logic [3:0][15:0] l;
        logic [3:0][15:0] r;
        int               stall_voice;
        int               stall_cycles;
        logic [15:0]      exp_l;
        logic [15:0]      exp_r;
        logic [15:0]      exp_m;
    } frame_vec_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] m;
    } exp_t;

    frame_vec_t vecs [7];
    exp_t       sb_q [$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_vec_t mkVec(
        input logic [15:0] l0, input logic [15:0] l1,
        input logic [15:0] l2, input logic [15:0] l3,
        input logic [15:0] r0, input logic [15:0] r1,
        input logic [15:0] r2, input logic [15:0] r3,
        input int sv, input int sc,
        input logic [15:0] el, input logic [15:0] er, input logic [15:0] em);
        frame_vec_t f;
        f.l            = {l3, l2, l1, l0};
        f.r            = {r3, r2, r1, r0};
        f.stall_voice  = sv;
        f.stall_cycles = sc;
        f.exp_l        = el;
        f.exp_r        = er;
        f.exp_m        = em;
        return f;
    endfunction

    // Scoreboard: every latch strobe must match the oldest pending frame.
    always @(negedge clk) begin
        if (latch_new_sample_in === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_latch actual=1 expected=0 at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("mix_left", new_sample_in_left, mon_e.l);
                checkOutput("mix_right", new_sample_in_right, mon_e.r);
                checkOutput("mix_mono", new_sample_in, mon_e.m);
            end
        end
    end

    // Runs one frame starting at a negedge; optionally injects an extra
    // frame pulse (and clear) in cycle extra_cyc. Returns at the negedge of
    // the first IDLE cycle after DONE.
    task automatic applyStimulus(input int v, input int extra_cyc, input bit clr_with_extra);
        int   k;
        int   cyc;
        int   stall_left;
        exp_t e;
        e.l = vecs[v].exp_l;
        e.r = vecs[v].exp_r;
        e.m = vecs[v].exp_m;
        sb_q.push_back(e);
        generate_next_sample = 1'b1;
        @(negedge clk);
        k          = 0;
        cyc        = 1;
        stall_left = vecs[v].stall_cycles;
        while (k < NV) begin
            generate_next_sample = (cyc == extra_cyc);
            clear_overrun        = clr_with_extra && (cyc == extra_cyc);
            checkOutput("voice_req", {31'd0, vbus.voice_req}, 32'd1);
            checkOutput("voice_idx", {30'd0, vbus.voice_idx}, k);
            checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
            if (k == vecs[v].stall_voice && stall_left > 0) begin
                vbus.voice_valid        = 1'b0;
                vbus.voice_sample_left  = 16'hDEAD;
                vbus.voice_sample_right = 16'hBEEF;
                stall_left--;
            end else begin
                vbus.voice_valid        = 1'b1;
                vbus.voice_sample_left  = vecs[v].l[k];
                vbus.voice_sample_right = vecs[v].r[k];
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        generate_next_sample    = (cyc == extra_cyc);
        clear_overrun           = clr_with_extra && (cyc == extra_cyc);
        vbus.voice_valid        = 1'b0;
        vbus.voice_sample_left  = 16'h5A5A;
        vbus.voice_sample_right = 16'hA5A5;
        checkOutput("latch_cycle", {31'd0, latch_new_sample_in}, 32'd1);
        checkOutput("req_in_done", {31'd0, vbus.voice_req}, 32'd0);
        @(negedge clk);
        generate_next_sample = 1'b0;
        clear_overrun        = 1'b0;
        checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
        checkOutput("latch_one_cycle", {31'd0, latch_new_sample_in}, 32'd0);
    endtask

    task automatic clearOverrun();
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        reset                   = 1'b1;
        generate_next_sample    = 1'b0;
        clear_overrun           = 1'b0;
        vbus.voice_valid        = 1'b0;
        vbus.voice_sample_left  = 16'h0000;
        vbus.voice_sample_right = 16'h0000;

        vecs[0] = mkVec(16'h0100, 16'h0100, 16'h0100, 16'h0100,
                        16'h0100, 16'h0100, 16'h0100, 16'h0100,
                        -1, 0, 16'h0400, 16'h0400, 16'h0400);
        vecs[1] = mkVec(16'h0010, 16'h0020, 16'h0030, 16'h0040,
                        16'hFFFF, 16'hFFFE, 16'h0005, 16'h0000,
                        2, 3, 16'h00A0, 16'h0002, 16'h0051);
`ifdef VOICE_MIX_SATURATE_EN
        vecs[2] = mkVec(16'h7000, 16'h7000, 16'h7000, 16'h7000,
                        16'h9000, 16'h9000, 16'h9000, 16'h9000,
                        -1, 0, 16'h7FFF, 16'h8000, 16'hFFFF);
        vecs[5] = mkVec(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                        16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                        0, 1, 16'h8000, 16'h7FFF, 16'hFFFF);
`else
        vecs[2] = mkVec(16'h7000, 16'h7000, 16'h7000, 16'h7000,
                        16'h9000, 16'h9000, 16'h9000, 16'h9000,
                        -1, 0, 16'hC000, 16'h4000, 16'h0000);
        vecs[5] = mkVec(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                        16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                        0, 1, 16'h0000, 16'hFFFC, 16'hFFFE);
`endif
        vecs[3] = mkVec(16'hFFFF, 16'hFFFE, 16'h0003, 16'h0000,
                        16'h0000, 16'h0000, 16'h0000, 16'h0000,
                        -1, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[4] = mkVec(16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                        16'h0000, 16'h0000, 16'h0000, 16'h0000,
                        -1, 0, 16'hFFFF, 16'h0000, 16'hFFFF);
        vecs[6] = mkVec(16'h7FFF, 16'h0000, 16'h0000, 16'h0000,
                        16'h8000, 16'h0000, 16'h0000, 16'h0000,
                        -1, 0, 16'h7FFF, 16'h8000, 16'hFFFF);

        repeat (3) @(negedge clk);
        checkOutput("reset_left", {16'd0, new_sample_in_left}, 32'd0);
        checkOutput("reset_right", {16'd0, new_sample_in_right}, 32'd0);
        checkOutput("reset_mono", {16'd0, new_sample_in}, 32'd0);
        checkOutput("reset_latch", {31'd0, latch_new_sample_in}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset_req", {31'd0, vbus.voice_req}, 32'd0);
        checkOutput("reset_idx", {30'd0, vbus.voice_idx}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back frames: each new pulse lands in the first IDLE cycle.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, 0, 1'b0);
        end
        checkOutput("no_overrun_back_to_back", {31'd0, overrun}, 32'd0);

        $display("[TB] overrun sequences");
        applyStimulus(0, 2, 1'b0);
        checkOutput("overrun_set_mid_frame", {31'd0, overrun}, 32'd1);
        clearOverrun();
        applyStimulus(1, 3, 1'b1);
        checkOutput("overrun_set_beats_clear", {31'd0, overrun}, 32'd1);
        clearOverrun();
        applyStimulus(0, 5, 1'b0);
        checkOutput("overrun_pulse_in_done", {31'd0, overrun}, 32'd1);
        clearOverrun();

        $display("[TB] reset mid-frame");
        generate_next_sample = 1'b1;
        @(negedge clk);
        generate_next_sample    = 1'b0;
        vbus.voice_valid        = 1'b1;
        vbus.voice_sample_left  = 16'h1234;
        vbus.voice_sample_right = 16'h4321;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_idx", {30'd0, vbus.voice_idx}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset            = 1'b0;
        vbus.voice_valid = 1'b0;
        checkOutput("midreset_left", {16'd0, new_sample_in_left}, 32'd0);
        checkOutput("midreset_right", {16'd0, new_sample_in_right}, 32'd0);
        checkOutput("midreset_mono", {16'd0, new_sample_in}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_req", {31'd0, vbus.voice_req}, 32'd0);
        checkOutput("midreset_idx", {30'd0, vbus.voice_idx}, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);
        applyStimulus(1, 0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voice_mix_scheduler.md
# voice_mix_scheduler

Sequences the per-voice sample generators once per codec frame. On each `generate_next_sample` pulse from the codec conditioner, it polls every voice in turn over a request/valid handshake and accumulates the signed stereo contributions. It then presents the clipped left, right and mono mix with a one-cycle `latch_new_sample_in` strobe. It sits between the codec conditioner and the voice bank, and is the only master of the shared voice-sample bus.

## Interface
- `NUM_VOICES`, default 4: number of voices polled per frame; 1 ≤ NUM_VOICES ≤ 2^IDX_W.
- `IDX_W`, default 2: width of `voice_idx`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; single clock domain.
- `generate_next_sample`  in  1  one-cycle pulse from the codec conditioner; starts a frame.
- `voice_req`  out  1  request for the sample of voice `voice_idx`.
- `voice_idx`  out  IDX_W  voice being polled; stable while `voice_req`=1.
- `voice_valid`  in  1  voice bank has `voice_sample_left`/`voice_sample_right` ready for `voice_idx`.
- `voice_sample_left`  in  16  signed two's-complement left contribution.
- `voice_sample_right`  in  16  signed two's-complement right contribution.
- `new_sample_in_left`  out  16  mixed left sample.
- `new_sample_in_right`  out  16  mixed right sample.
- `new_sample_in`  out  16  mono mix.
- `latch_new_sample_in`  out  1  one-cycle strobe; all three sample outputs valid in this cycle.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky: a frame request arrived while busy.
- `clear_overrun`  in  1  clears `overrun`.

## Operation
- Accumulators: `acc_l`, `acc_r`, each signed, ACC_W = 16+IDX_W+1 bits. Operands are sign-extended before adding, so the accumulators never overflow.
- State IDLE:
  - On `generate_next_sample`: clear both accumulators, set idx=0, go to REQ.
- State REQ:
  - `voice_req`=1, `voice_idx`=idx.
  - When `voice_valid`=1: add the sign-extended samples into the accumulators.
  - If idx==NUM_VOICES-1, register the final results into the output registers and go to DONE. Otherwise increment idx and stay in REQ.
  - With `voice_valid`=0, hold `voice_req`, idx and the accumulators indefinitely. There is no timeout.
- State DONE:
  - `latch_new_sample_in`=1 for exactly this cycle, then go to IDLE.
- Final results:
  - Clipping per channel (see Configuration) gives L16 and R16.
  - Mono = (sext17(L16)+sext17(R16)) >>> 1, arithmetic shift, truncated toward −∞, low 16 bits.
- Output registers change only on the DONE-entry edge. They hold their values until the next frame completes.
- `voice_valid` outside REQ is ignored. Voice sample inputs are sampled only in REQ cycles with `voice_valid`=1.
- Overrun:
  - `generate_next_sample` while `busy`=1 sets `overrun`. The pulse is otherwise dropped and the current frame continues unchanged.
  - `clear_overrun` clears `overrun`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, idx 0, `voice_req` 0, `voice_idx` 0, `latch_new_sample_in` 0, `busy` 0, `overrun` 0, all sample outputs 16'h0000, accumulators 0.
- Reset mid-frame aborts the frame with no latch strobe. Outputs return to 0 on the next edge.
- Cycle numbering: the pulse is sampled at edge 0.
  - `voice_req` is high from cycle 1.
  - With `voice_valid` tied high, voice k is accepted at edge k+1.
  - `latch_new_sample_in` is high in cycle NUM_VOICES+1.
  - `busy` falls in cycle NUM_VOICES+2.
- Minimum frame length: NUM_VOICES+2 cycles, pulse to IDLE. Each wait cycle with `voice_valid`=0 adds one cycle.
- A pulse arriving in the DONE cycle counts as an overrun. A pulse in the first IDLE cycle after DONE starts a new frame.
- All outputs are registered except `latch_new_sample_in`, `voice_req` and `busy`, which decode the registered state.

## Configuration
- `VOICE_MIX_SATURATE_EN` defined:
  - Each channel is clipped to [−32768, 32767].
  - Sums above the range give 16'h7FFF; sums below give 16'h8000.
- `VOICE_MIX_SATURATE_EN` undefined:
  - Each channel is the low 16 bits of its accumulator (two's-complement wrap).
  - No extra logic on the result path.

## Test plan
- Reset, NUM_VOICES=4, `voice_valid` tied 1, samples L=R=16'h0100 per voice. Pulse -> `voice_idx` 0,1,2,3 in cycles 1–4; `latch_new_sample_in` in cycle 5; L=R=mono=16'h0400; `busy` low in cycle 6.
- `voice_valid` low for 3 cycles on voice 2 -> `voice_req` and `voice_idx`=2 held throughout; latch in cycle 8; sums correct.
- With SATURATE_EN: four voices at L=16'h7000, R=16'h9000 -> L=16'h7FFF, R=16'h8000, mono=16'hFFFF. Without SATURATE_EN: L=16'hC000, R=16'h4000, mono=16'h0000.
- Second pulse in cycle 2 of a frame -> `overrun`=1, frame completes normally with a single latch. `clear_overrun` asserted in the same cycle as a new overrun pulse -> `overrun` stays 1. `clear_overrun` alone -> 0.
- `reset` asserted in cycle 3 of a frame -> no latch strobe; all outputs 0 next cycle; a new pulse afterwards produces a full, correct frame.
- Mixed signs: L samples −1, −2, 3, 0; R samples all 0 -> L=16'h0000, mono=16'h0000. L samples −1, 0, 0, 0 -> L=16'hFFFF, mono=16'hFFFF (rounding toward −∞).
